pipe_stage_q: RTL



---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_stage_q_if.sv | 29 ++
 rtl/pipe_slice.sv | 52 +++++
 rtl/pipe_stage_q.sv | 84 ++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the parametrised pipeline-register queue.
package pipe_pkg;

  localparam int unsigned PIPE_MAX_DEPTH = 4;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_q_if.sv
// Upstream/downstream handshake bundle of one pipeline boundary queue.
interface pipe_stage_q_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_halt;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_halt;
  logic [occ_w(DEPTH)-1:0]   occupancy;

  modport slave (
    input  in_valid, in_data, in_halt, out_ready,
    output in_ready, out_valid, out_data, out_halt, occupancy
  );

  modport master (
    output in_valid, in_data, in_halt, out_ready,
    input  in_ready, out_valid, out_data, out_halt, occupancy
  );

endinterface

// File: rtl/pipe_slice.sv
// One register slice: valid/data/halt with load, leave and flush-clear.
module pipe_slice #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              leave_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              halt_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              halt_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              halt_q, halt_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    halt_d  = halt_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      halt_d  = halt_i;
    end else if (leave_i) begin
      valid_d = 1'b0;
    end
    // Flush kills the word but leaves the payload registers untouched.
    if (clear_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      halt_q  <= halt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign halt_o  = halt_q;

endmodule

// File: rtl/pipe_stage_q.sv
// DEPTH-slice pipeline register queue with bubble collapsing, flush and sticky halt.
module pipe_stage_q
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           en,
  input  logic           flush,
  pipe_stage_q_if.slave  bus
);

  localparam int unsigned OCC_W = occ_w(DEPTH);

  logic [DEPTH-1:0]  valid, halt, move, load, src_halt;
  logic [DATA_W-1:0] data     [DEPTH];
  logic [DATA_W-1:0] src_data [DEPTH];
  logic              room, mv, in_ready;
  logic              out_halt_q, out_halt_d;
  logic [OCC_W-1:0]  occ;

  // Walk from the output slice back to slice 0; "room" is whether the slice
  // ahead is empty or emptying, which replaces the recursive move definition.
  always_comb begin
    move = '0;
    room = bus.out_ready;
    mv   = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      mv                = en & valid[DEPTH-1-k] & room;
      move[DEPTH-1-k]   = mv;
      room              = ~valid[DEPTH-1-k] | mv;
    end
    in_ready = en & ~out_halt_q & room;
  end

  always_comb begin
    load        = '0;
    src_halt    = '0;
    load[0]     = in_ready & bus.in_valid;
    src_data[0] = bus.in_data;
    src_halt[0] = bus.in_halt;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      load[k]     = move[k-1];
      src_data[k] = data[k-1];
      src_halt[k] = halt[k-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slice
    pipe_slice #(.DATA_W(DATA_W)) u_slice (
      .clk_i   (CLK),
      .rst_ni  (nRST),
      .load_i  (load[g]),
      .leave_i (move[g]),
      .clear_i (flush),
      .data_i  (src_data[g]),
      .halt_i  (src_halt[g]),
      .valid_o (valid[g]),
      .data_o  (data[g]),
      .halt_o  (halt[g])
    );
  end

  assign out_halt_d = out_halt_q | (move[DEPTH-1] & halt[DEPTH-1]);

  always_ff @(posedge CLK) begin
    if (!nRST) out_halt_q <= 1'b0;
    else       out_halt_q <= out_halt_d;
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occ = occ + OCC_W'(valid[k]);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];
  assign bus.out_halt  = out_halt_q;
  assign bus.occupancy = occ;

endmodule
